// File: rtl/quadrature_gen_if.sv
// quadrature_gen_if: move-request handshake (direction, edge count, phase divider) into quadrature_gen.
interface quadrature_gen_if #(
    parameter int step_width = 8,
    parameter int div_width  = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_dir;
    logic [step_width-1:0] req_steps;
    logic [div_width-1:0]  div;
    modport master(output req_valid, req_dir, req_steps, div, input req_ready);
    modport slave(input req_valid, req_dir, req_steps, div, output req_ready);
endinterface

// File: rtl/quadrature_gen.sv
// quadrature_gen: emits a two-phase A/B sequence for each move request and tracks the emitted position.
// Optional contact-bounce emulation on each edge when QUADRATURE_GEN_BOUNCE_EN is defined.
module quadrature_gen #(
    parameter int w          = 16,
    parameter int step_width = 8,
    parameter int div_width  = 10
) (
    input  logic          clk,
    input  logic          reset,
    quadrature_gen_if.slave req,
    output logic          a,
    output logic          b,
    output logic          busy,
    output logic          done,
    output logic [w-1:0]  position
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [div_width-1:0]  div_q, div_d, cnt_q, cnt_d;
    logic [step_width-1:0] rem_q, rem_d;
    logic                  a_q, a_d, b_q, b_d, done_q, done_d;
    logic [w-1:0]          pos_q, pos_d;
    logic                  adv;

    assign req.req_ready = state_q == IDLE;
    assign busy          = state_q == RUN;
    assign done          = done_q;
    assign position      = pos_q;

    always_comb begin
        adv     = state_q == RUN && cnt_q == '0;
        state_d = state_q;
        dir_d   = dir_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        a_d     = a_q;
        b_d     = b_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (req.req_valid) begin
                dir_d   = req.req_dir;
                div_d   = req.div;
                cnt_d   = req.div;
                rem_d   = req.req_steps;
                done_d  = req.req_steps == '0;
                state_d = req.req_steps == '0 ? IDLE : RUN;
            end
        end else begin
            cnt_d = adv ? div_q : cnt_q - 1'b1;
            if (adv) begin
                // Increment rotates 00->10->11->01; decrement is the reverse.
                a_d     = dir_q ? ~b_q : b_q;
                b_d     = dir_q ? a_q : ~a_q;
                pos_d   = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
                rem_d   = rem_q - 1'b1;
                done_d  = rem_q == step_width'(1);
                state_d = rem_q == step_width'(1) ? IDLE : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pos_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
        end
    end

`ifdef QUADRATURE_GEN_BOUNCE_EN
    // bnc counts 2,1,0 after an edge; at 1 the changed channel briefly reverts.
    logic [1:0] bnc_q, bnc_d, mk_q, mk_d;
    logic       ao_q, bo_q;

    always_comb begin
        bnc_d = bnc_q == 2'd0 ? 2'd0 : bnc_q - 2'd1;
        mk_d  = mk_q;
        if (adv && div_q >= div_width'(2)) begin
            bnc_d = 2'd2;
            mk_d  = {a_d ^ a_q, b_d ^ b_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bnc_q <= 2'd0;
            mk_q  <= 2'd0;
            ao_q  <= 1'b0;
            bo_q  <= 1'b0;
        end else begin
            bnc_q <= bnc_d;
            mk_q  <= mk_d;
            ao_q  <= a_d ^ (mk_d[1] & (bnc_d == 2'd1));
            bo_q  <= b_d ^ (mk_d[0] & (bnc_d == 2'd1));
        end
    end

    assign a = ao_q;
    assign b = bo_q;
`else
    assign a = a_q;
    assign b = b_q;
`endif
endmodule

// File: tb/tb_quadrature_gen.sv
// tb_quadrature_gen: directed and randomized move requests checked every cycle against a timing-formula model.
module tb_quadrature_gen;
`ifdef QUADRATURE_GEN_BOUNCE_EN
    localparam bit BNC = 1'b1;
`else
    localparam bit BNC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset;
    logic        a, b, busy, done;
    logic [15:0] position;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    quadrature_gen_if iface ();

    quadrature_gen dut (
        .clk(clk), .reset(reset), .req(iface.slave),
        .a(a), .b(b), .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Model: edge k of a request lands k*(div+1) cycles after acceptance.
    int       m_pos = 0, m_ph = 0, m_t = 0, m_e = 0, m_n = 0, m_d = 0, m_sa = 3, m_bd = 0;
    bit       m_act = 0, m_done = 0, m_dir = 0;
    logic [1:0] m_prev = 2'b00;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_done = 1'b0;
        if (m_sa < 3) m_sa++;
        if (reset) begin
            m_act = 0; m_pos = 0; m_ph = 0; m_sa = 3; m_prev = 2'b00;
        end else if (m_act) begin
            m_t++;
            if (m_t % (m_d + 1) == 0) begin
                m_prev = ab_tab[m_ph];
                m_ph   = (m_ph + (m_dir ? 1 : 3)) % 4;
                m_pos  = (m_pos + (m_dir ? 1 : 65535)) % 65536;
                m_sa   = 0;
                m_bd   = m_d;
                m_e++;
                if (m_e == m_n) begin
                    m_act  = 0;
                    m_done = 1;
                end
            end
        end else if (iface.req_valid) begin
            if (iface.req_steps == 0) m_done = 1;
            else begin
                m_act = 1; m_t = 0; m_e = 0;
                m_n = int'(iface.req_steps); m_d = int'(iface.div); m_dir = iface.req_dir;
            end
        end
    end

    initial forever begin
        logic [1:0]  eab;
        logic [15:0] epos;
        @(negedge clk);
        if (chk_en) begin
            eab  = (BNC && m_bd >= 2 && m_sa == 1) ? m_prev : ab_tab[m_ph];
            epos = m_pos[15:0];
            chk("model", {11'd0, a, b, position, busy, done, iface.req_ready},
                {11'd0, eab, epos, m_act, m_done, ~m_act});
        end
    end

    task automatic send(input bit d, input int n, input int dv);
        iface.req_dir = d; iface.req_steps = 8'(n); iface.div = 10'(dv); iface.req_valid = 1'b1;
        @(negedge clk);
        iface.req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit ok, rdy;
        reset = 1'b1;
        iface.req_valid = 1'b0; iface.req_dir = 1'b0; iface.req_steps = '0; iface.div = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset", {a, b, position, busy, done, iface.req_ready}, {2'b00, 16'h0000, 3'b001});
        reset = 1'b0;
        send(1, 4, 3);
        chk("inc_busy", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            repeat (4) @(negedge clk);
            chk("inc_ab", {a, b}, ab_tab[k % 4]);
            chk("inc_pos", position, k);
        end
        chk("inc_done", {done, busy}, 2'b10);
        pulse_reset();
        send(0, 2, 0);
        @(negedge clk);
        chk("dec1", {a, b, position}, {2'b01, 16'hFFFF});
        @(negedge clk);
        chk("dec2", {a, b, position, done}, {2'b11, 16'hFFFE, 1'b1});
        send(1, 2, 0);
        @(negedge clk);
        chk("wrap1", position, 16'hFFFF);
        @(negedge clk);
        chk("wrap2", {a, b, position}, {2'b00, 16'h0000});
        send(1, 0, 2);
        chk("zero", {a, b, position, busy, done}, {2'b00, 16'h0000, 2'b01});
        @(negedge clk);
        chk("zero_after", {busy, done}, 2'b00);
        iface.req_dir = 1'b1; iface.req_steps = 8'd5; iface.div = 10'd1; iface.req_valid = 1'b1;
        @(negedge clk);
        iface.req_dir = 1'b0; iface.req_steps = 8'd1; iface.div = 10'd2;
        repeat (9) @(negedge clk);
        chk("hold_run", {busy, position}, {1'b1, 16'd4});
        @(negedge clk);
        chk("hold_done", {a, b, position, busy, done}, {2'b10, 16'd5, 2'b01});
        @(negedge clk);
        iface.req_valid = 1'b0;
        chk("hold_acc", busy, 1);
        repeat (2) @(negedge clk);
        chk("hold_wait", position, 16'd5);
        @(negedge clk);
        chk("hold_edge", {a, b, position, done}, {2'b00, 16'd4, 1'b1});
        send(1, 5, 3);
        repeat (8) @(negedge clk);
        chk("mid_pos", position, 16'd6);
        pulse_reset();
        chk("mid_rst", {a, b, position, busy, done, iface.req_ready}, {2'b00, 16'h0000, 3'b001});
        @(negedge clk);
        chk("mid_nodone", {busy, done}, 2'b00);
`ifdef QUADRATURE_GEN_BOUNCE_EN
        send(1, 1, 7);
        repeat (8) @(negedge clk);
        chk("bnc1", {a, b, position}, {2'b10, 16'd1});
        @(negedge clk);
        chk("bnc2", {a, b}, 2'b00);
        @(negedge clk);
        chk("bnc3", {a, b}, 2'b10);
        @(negedge clk);
        chk("bnc4", {a, b}, 2'b10);
`endif
        for (int i = 0; i < 60; i++) begin
            iface.req_dir   = 1'($urandom_range(0, 1));
            iface.req_steps = 8'($urandom_range(0, 12));
            iface.div       = 10'($urandom_range(0, 5));
            iface.req_valid = 1'b1;
            ok = 1'b0;
            for (int j = 0; j < 300 && !ok; j++) begin
                rdy = iface.req_ready;
                @(negedge clk);
                ok = rdy;
            end
            chk("accept", ok, 1);
            iface.req_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                pulse_reset();
            end else begin
                repeat ($urandom_range(0, 15)) @(negedge clk);
            end
        end
        repeat (80) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
